// File: rtl/multiword_pkg.sv
// Shared FSM state type and state-encoding constants for the multiword add sequencer.
package multiword_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/giulio_fast_adder.sv
// Combinational WIDTH-bit carry-select adder built from BLOCK_WIDTH-bit blocks.
module giulio_fast_adder #(
  parameter int WIDTH       = 16,
  parameter int BLOCK_WIDTH = 4
) (
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  output logic [WIDTH-1:0] oS,
  output logic             oC
);

  localparam int NBLK = WIDTH / BLOCK_WIDTH;

  logic [NBLK:0] blkCarry;

  assign blkCarry[0] = iC;

  // Each block precomputes both carry-in outcomes; the incoming block carry only selects.
  for (genvar g = 0; g < NBLK; g++) begin : gBlk
    logic [BLOCK_WIDTH:0] sum0;
    logic [BLOCK_WIDTH:0] sum1;

    assign sum0 = {1'b0, iA[g*BLOCK_WIDTH +: BLOCK_WIDTH]}
                + {1'b0, iB[g*BLOCK_WIDTH +: BLOCK_WIDTH]};
    assign sum1 = {1'b0, iA[g*BLOCK_WIDTH +: BLOCK_WIDTH]}
                + {1'b0, iB[g*BLOCK_WIDTH +: BLOCK_WIDTH]}
                + {{BLOCK_WIDTH{1'b0}}, 1'b1};

    assign oS[g*BLOCK_WIDTH +: BLOCK_WIDTH] = blkCarry[g] ? sum1[BLOCK_WIDTH-1:0]
                                                          : sum0[BLOCK_WIDTH-1:0];
    assign blkCarry[g+1] = blkCarry[g] ? sum1[BLOCK_WIDTH] : sum0[BLOCK_WIDTH];
  end

  assign oC = blkCarry[NBLK];

endmodule

// File: rtl/multiword_add_sequencer.sv
// N-bit adder that processes one WIDTH-bit slice per cycle through a single slice adder.
// Optional subtract mode (iSub, oOvf) is enabled by defining MULTIWORD_ADD_SEQUENCER_SUB_EN.
module multiword_add_sequencer
  import multiword_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int BLOCK_WIDTH = 4,
  parameter int NWORDS      = 4
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iStart,
  input  logic [NWORDS*WIDTH-1:0]  iA,
  input  logic [NWORDS*WIDTH-1:0]  iB,
  input  logic                     iC,
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
  input  logic                     iSub,
  output logic                     oOvf,
`endif
  output logic                     oBusy,
  output logic                     oDone,
  output logic [NWORDS*WIDTH-1:0]  oS,
  output logic                     oC
);

  localparam int N     = NWORDS * WIDTH;
  localparam int IDX_W = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t           state;
  state_t           stateNext;
  logic [N-1:0]     aReg;
  logic [N-1:0]     bReg;
  logic             carryReg;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] aSlice;
  logic [WIDTH-1:0] bSlice;
  logic [WIDTH-1:0] sumSlice;
  logic             carrySlice;

  assign aSlice = aReg[int'(idx)*WIDTH +: WIDTH];

`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
  logic subReg;
  logic ovfSlice;

  assign bSlice   = subReg ? ~bReg[int'(idx)*WIDTH +: WIDTH] : bReg[int'(idx)*WIDTH +: WIDTH];
  // Signed overflow: operands share a sign that the result does not.
  assign ovfSlice = (aSlice[WIDTH-1] == bSlice[WIDTH-1]) && (sumSlice[WIDTH-1] != aSlice[WIDTH-1]);
`else
  assign bSlice = bReg[int'(idx)*WIDTH +: WIDTH];
`endif

  giulio_fast_adder #(
    .WIDTH       (WIDTH),
    .BLOCK_WIDTH (BLOCK_WIDTH)
  ) uSliceAdder (
    .iA (aSlice),
    .iB (bSlice),
    .iC (carryReg),
    .oS (sumSlice),
    .oC (carrySlice)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= stateNext;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    stateNext = state;
    oBusy     = 1'b0;
    oDone     = 1'b0;
    unique case (state)
      IDLE: if (iStart) stateNext = RUN;
      RUN: begin
        oBusy = 1'b1;
        if (idx == LAST_IDX) stateNext = DONE;
      end
      DONE: begin
        oBusy     = 1'b1;
        oDone     = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      aReg     <= '0;
      bReg     <= '0;
      carryReg <= 1'b0;
      idx      <= '0;
      oS       <= '0;
      oC       <= 1'b0;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
      subReg   <= 1'b0;
      oOvf     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (iStart) begin
          aReg     <= iA;
          bReg     <= iB;
          idx      <= '0;
          carryReg <= iC;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
          subReg   <= iSub;
          if (iSub) carryReg <= 1'b1;
`endif
        end
        RUN: begin
          oS[int'(idx)*WIDTH +: WIDTH] <= sumSlice;
          carryReg <= carrySlice;
          if (idx == LAST_IDX) begin
            oC   <= carrySlice;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
            oOvf <= ovfSlice;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bits per slice processed each cycle.
REQ-002 SHALL have parameter BLOCK_WIDTH, default 4: block width passed to the slice adder; WIDTH SHALL be a multiple of BLOCK_WIDTH.
REQ-003 SHALL have parameter NWORDS, default 4: slices per operand, NWORDS >= 2; total operand width N = NWORDS*WIDTH.
REQ-004 SHALL have port iClk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port iRstN, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port iStart, input, 1: request to begin an N-bit addition.
REQ-007 SHALL have ports iA and iB, input, N each: operands, sampled only on an accepted start.
REQ-008 SHALL have port iC, input, 1: carry-in, sampled only on an accepted start.
REQ-009 SHALL have port oBusy, output, 1: high while an operation is in progress (RUN or DONE state).
REQ-010 SHALL have port oDone, output, 1: one-cycle pulse when the result is valid.
REQ-011 SHALL have port oS, output, N: sum, registered.
REQ-012 SHALL have port oC, output, 1: final carry-out, registered.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 In IDLE with iStart=1, SHALL latch iA, iB and iC, clear the slice index to 0, and enter RUN; the start is then accepted.
REQ-015 iStart in RUN or DONE SHALL be ignored, with no latching and no queueing.
REQ-016 In RUN, each cycle SHALL add slice[idx] of A and B plus the carry register through one WIDTH-bit slice adder.
REQ-017 In the same RUN cycle, SHALL write that sum into oS[idx*WIDTH +: WIDTH], load the carry register with the slice carry-out, and increment idx.
REQ-018 When idx=NWORDS-1 in RUN, SHALL enter DONE, copy the final carry into oC, and not increment idx past NWORDS-1.
REQ-019 In DONE, oDone SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 Latency: with the start accepted on edge t, oDone SHALL be high in the cycle after edge t+NWORDS; total NWORDS+1 cycles per operation.
REQ-021 oS and oC SHALL hold the last result until the next accepted start.
REQ-022 During RUN, oS slices not yet written SHALL retain their previous values.
REQ-023 Arithmetic SHALL be modulo 2^N, with {oC,oS} = A + B + carry-in exactly, including the all-ones wrap case.
REQ-024 Back-to-back operation: iStart held high continuously SHALL start a new operation in the IDLE cycle following DONE, one start every NWORDS+2 cycles.

Reset
REQ-025 Asserting iRstN low at any time, including mid-RUN, SHALL immediately abort the operation.
REQ-026 On reset: FSM=IDLE, idx=0, carry register=0, oS=0, oC=0, oBusy=0, oDone=0.
REQ-027 After deassertion, the first accepted start SHALL behave as from power-up.

Configuration
REQ-028 Macro MULTIWORD_ADD_SEQUENCER_SUB_EN SHALL control an optional subtract feature.
REQ-029 When the macro is defined: add input port iSub (1 bit, sampled on start) and output port oOvf (1 bit, registered, reset 0).
REQ-030 When defined and iSub=1: the operation SHALL be A - B, with B inverted per slice and the initial carry forced to 1 (iC ignored).
REQ-031 When defined: oOvf SHALL be the signed two's-complement overflow of the N-bit result, updated with oC.
REQ-032 When defined: oC SHALL equal the raw carry-out, so that oC=1 means no borrow.
REQ-033 When the macro is undefined: iSub and oOvf SHALL be absent and the block SHALL add only.

Structure
REQ-034 A shared package multiword_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the state-encoding constants.
REQ-035 Index width SHALL be $clog2(NWORDS), computed locally.
REQ-036 The single sub-module SHALL be the existing combinational carry-select/CLA slice adder giulio_fast_adder, instantiated once, unmodified, with WIDTH and BLOCK_WIDTH passed through.
REQ-037 All sequencing, slice muxing and carry registration SHALL reside in multiword_add_sequencer.

Verification (WIDTH=16, NWORDS=4, N=64)
REQ-038 Carry ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=1, iC=0 -> oS=0, oC=1, oDone exactly 5 cycles after the start edge.
REQ-039 Carry-in only: A=0x0123_4567_89AB_CDEF, B=0, iC=1 -> oS=0x0123_4567_89AB_CDF0, oC=0.
REQ-040 Ignored start: start A=1, B=1; pulse iStart with A=B=0xFFFF... during RUN -> oS=2, a single oDone pulse, oBusy high for 5 cycles.
REQ-041 Reset mid-op: assert iRstN low on the 2nd RUN cycle -> oS=0, oC=0, oBusy=0, no oDone; a subsequent start of 5+7 -> oS=12.
REQ-042 Back-to-back: iStart held high with two operand sets -> oDone pulses 6 cycles apart, each result correct.
REQ-043 With SUB_EN: A=0x8000_0000_0000_0000, B=1, iSub=1 -> oS=0x7FFF_FFFF_FFFF_FFFF, oC=1, oOvf=1; and 0-1 -> oS=all ones, oC=0, oOvf=0.
